// File: rtl/alu16_pkg.sv
// Shared definitions for the Hack-style ALU stage: control-bit positions and the
// standard opcode encodings of the {zx,nx,zy,ny,f,no} control word.
package alu16_pkg;

    localparam int ZX = 5;
    localparam int NX = 4;
    localparam int ZY = 3;
    localparam int NY = 2;
    localparam int F  = 1;
    localparam int NO = 0;

    localparam logic [5:0] OP_ZERO = 6'b101010;
    localparam logic [5:0] OP_ONE  = 6'b111111;
    localparam logic [5:0] OP_X    = 6'b001100;
    localparam logic [5:0] OP_NOTX = 6'b001101;
    localparam logic [5:0] OP_ADD  = 6'b000010;
    localparam logic [5:0] OP_SUB  = 6'b010011;
    localparam logic [5:0] OP_AND  = 6'b000000;
    localparam logic [5:0] OP_OR   = 6'b010101;

endpackage

// File: rtl/alu16.sv
// Purely combinational Hack ALU: Not/And gate stages on each operand, then an
// adder or an And, then an optional output inversion.
module alu16
    import alu16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [5:0]       i_ctrl,
    output logic [WIDTH-1:0] o_out,
    output logic             o_zr,
    output logic             o_ng
);

    logic [WIDTH-1:0] w_x1;
    logic [WIDTH-1:0] w_x2;
    logic [WIDTH-1:0] w_y1;
    logic [WIDTH-1:0] w_y2;
    logic [WIDTH-1:0] w_o;

    // Operand conditioning, function select (carry out of the add is dropped), output negate
    always_comb begin
        w_x1  = i_ctrl[ZX] ? {WIDTH{1'b0}} : i_x;
        w_x2  = i_ctrl[NX] ? ~w_x1 : w_x1;
        w_y1  = i_ctrl[ZY] ? {WIDTH{1'b0}} : i_y;
        w_y2  = i_ctrl[NY] ? ~w_y1 : w_y1;
        w_o   = i_ctrl[F] ? (w_x2 + w_y2) : (w_x2 & w_y2);
        o_out = i_ctrl[NO] ? ~w_o : w_o;
        o_zr  = (o_out == {WIDTH{1'b0}});
        o_ng  = o_out[WIDTH-1];
    end

endmodule

// File: rtl/alu16_stage.sv
// Registered ALU stage: one operation per cycle over valid/ready, results and
// flags buffered in a small FIFO so a stalled consumer never loses data.
module alu16_stage
    import alu16_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);

    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = WIDTH + 2;

    logic [WIDTH-1:0] w_alu_out;
    logic             w_alu_zr;
    logic             w_alu_ng;
    logic             w_push;
    logic             w_pop;
    logic [PW-1:0]    w_head_ptr;

    logic [EW-1:0]    r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    alu16 #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_x    (x),
        .i_y    (y),
        .i_ctrl (ctrl),
        .o_out  (w_alu_out),
        .o_zr   (w_alu_zr),
        .o_ng   (w_alu_ng)
    );

    // Handshake qualification; an empty FIFO shows the entry just behind rd_ptr,
    // which is the last popped result and is not overwritten until a push refills it.
    always_comb begin
        in_ready   = rst_n & (r_count != CW'(DEPTH));
        out_valid  = (r_count != {CW{1'b0}});
        w_push     = in_valid & in_ready;
        w_pop      = out_valid & out_ready;
        w_head_ptr = out_valid ? r_rd_ptr : (r_rd_ptr - PW'(1));
        {out, zr, ng} = r_mem[w_head_ptr];
    end

    // Result storage; cleared on reset so the visible head reads as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {EW{1'b0}};
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= {w_alu_out, w_alu_zr, w_alu_ng};
        end
    end

    // Pointers and occupancy count; power-of-two depth makes pointer wrap natural
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
